// File: rtl/reg_list_sequencer_pkg.sv
// Shared constants and state encoding for the LDM/STM register-list sequencer.
package reg_list_sequencer_pkg;

  localparam int REGS = 16;  // one bit per architectural register
  localparam int IDXW = 4;   // clog2(REGS)
  localparam int OFFW = 7;   // holds (REGS-1)*4 = 60
  localparam int CNTW = 5;   // reaches 16 after a full list without wrapping

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/reg_list_sequencer_lsb.sv
// Lowest-set-bit priority encoder: index of the lowest 1 in vec, plus an any flag.
module lsb_priority_encoder
  import reg_list_sequencer_pkg::*;
(
  input  logic [REGS-1:0] vec,
  output logic [IDXW-1:0] idx,
  output logic            any
);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which is what would otherwise infer a latch.
    idx = '0;
    any = |vec;
    // Scan high to low so the lowest set bit is the final write that sticks.
    for (int i = REGS - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDXW'(i);
    end
  end

endmodule

// File: rtl/reg_list_sequencer.sv
// Emits the lowest pending register of an LDM/STM list once per cycle, with a
// one-hot register-file write strobe and the byte offset from the base address.
module reg_list_sequencer
  import reg_list_sequencer_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [REGS-1:0] reg_list,
  input  logic            stall,
  output logic            ready,
  output logic            valid,
  output logic [IDXW-1:0] reg_num,
  output logic [REGS-1:0] reg_we,
  output logic [OFFW-1:0] offset,
  output logic            last,
  output logic            done
);

  state_t            state_q, state_d;
  logic [REGS-1:0]   pending_q;
  logic [CNTW-1:0]   count_q;
  logic [IDXW-1:0]   enc_idx;
  logic              enc_any;
  logic              xfer;

  lsb_priority_encoder u_enc (
    .vec (pending_q),
    .idx (enc_idx),
    .any (enc_any)
  );

  // Pending is always zero outside RUN, so reg_num reads 0 there.
  assign ready   = (state_q == ST_IDLE);
  assign valid   = (state_q == ST_RUN) && enc_any;
  assign reg_num = enc_idx;
  assign offset  = OFFW'({count_q, 2'b00});
  assign last    = valid && ((pending_q & (pending_q - 1'b1)) == '0);
  assign done    = (state_q == ST_DONE);
  assign xfer    = valid && !stall;
  assign reg_we  = xfer ? (REGS'(1) << reg_num) : '0;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = (reg_list != '0) ? ST_RUN : ST_DONE;
      ST_RUN:  if (xfer && last) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      count_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && start) begin
        pending_q <= reg_list;
        count_q   <= '0;
      end else if (xfer) begin
        pending_q <= pending_q & (pending_q - 1'b1);
        count_q   <= count_q + 1'b1;
      end
    end
  end

endmodule
